// File: rtl/cache_rd_arbiter.sv
// Shares one AXI4 read channel between I-cache and D-cache refills; request-to-arvalid is one cycle, R beats are forwarded with zero latency.
// Each requester has a 1-deep pending slot (rd_rdy drops while it is full or the requester owns the bus); CACHE_RD_ARB_RR_EN selects round-robin over D-first ties.
module cache_rd_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int LINE_BEATS = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_rd_req,
  input  logic [2:0]        i_rd_type,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              i_rd_rdy,
  output logic              i_ret_valid,
  output logic              i_ret_last,
  output logic [DATA_W-1:0] i_ret_data,
  input  logic              d_rd_req,
  input  logic [2:0]        d_rd_type,
  input  logic [ADDR_W-1:0] d_rd_addr,
  output logic              d_rd_rdy,
  output logic              d_ret_valid,
  output logic              d_ret_last,
  output logic [DATA_W-1:0] d_ret_data,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic              arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rlast,
  input  logic              rid,
  input  logic [1:0]        rresp,
  output logic              rd_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [7:0] LINE_LEN = 8'(LINE_BEATS - 1);

  state_t            state, state_nxt;
  logic              owner;
  logic              pend_i, pend_d;
  logic [2:0]        pend_i_type, pend_d_type;
  logic [ADDR_W-1:0] pend_i_addr, pend_d_addr;
  logic              cap_i, cap_d, want_i, want_d;
  logic              grant, grant_d, beat;
  logic [2:0]        sel_type;
  logic [ADDR_W-1:0] sel_addr;
`ifdef CACHE_RD_ARB_RR_EN
  logic              last_d;
`endif

  assign i_rd_rdy = ~pend_i & ~((state != IDLE) & ~owner);
  assign d_rd_rdy = ~pend_d & ~((state != IDLE) & owner);
  assign cap_i    = i_rd_req & i_rd_rdy;
  assign cap_d    = d_rd_req & d_rd_rdy;
  // A fresh pulse competes in the same cycle so an idle bus issues AR one cycle after the request.
  assign want_i   = pend_i | cap_i;
  assign want_d   = pend_d | cap_d;
  assign beat     = (state == DATA) & rvalid & rready;
  assign arid     = owner;
  assign arburst  = 2'b01;

  assign i_ret_valid = beat & ~owner;
  assign i_ret_last  = i_ret_valid & rlast;
  assign i_ret_data  = i_ret_valid ? rdata : '0;
  assign d_ret_valid = beat & owner;
  assign d_ret_last  = d_ret_valid & rlast;
  assign d_ret_data  = d_ret_valid ? rdata : '0;

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (want_i | want_d) begin
          grant     = 1'b1;
`ifdef CACHE_RD_ARB_RR_EN
          grant_d   = want_d & (~want_i | ~last_d);
`else
          grant_d   = want_d;
`endif
          state_nxt = ADDR;
        end
      end
      ADDR:    if (arvalid & arready) state_nxt = DATA;
      DATA:    if (beat & rlast)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_type = 3'b000;
    sel_addr = '0;
    if (grant_d) begin
      sel_type = pend_d ? pend_d_type : d_rd_type;
      sel_addr = pend_d ? pend_d_addr : d_rd_addr;
    end else begin
      sel_type = pend_i ? pend_i_type : i_rd_type;
      sel_addr = pend_i ? pend_i_addr : i_rd_addr;
    end
  end

`ifdef CACHE_RD_ARB_RR_EN
  // Only contested grants move the pointer; an uncontested grant leaves tie priority alone.
  always_ff @(posedge clock) begin
    if (!reset)                          last_d <= 1'b0;
    else if (grant & want_i & want_d)    last_d <= grant_d;
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      pend_i      <= 1'b0;
      pend_d      <= 1'b0;
      pend_i_type <= 3'b000;
      pend_d_type <= 3'b000;
      pend_i_addr <= '0;
      pend_d_addr <= '0;
      arvalid     <= 1'b0;
      araddr      <= '0;
      arlen       <= 8'd0;
      arsize      <= 3'd0;
      owner       <= 1'b0;
      rready      <= 1'b0;
      rd_err      <= 1'b0;
    end else begin
      if (grant & ~grant_d) pend_i <= 1'b0;
      else if (cap_i)       pend_i <= 1'b1;
      if (grant & grant_d)  pend_d <= 1'b0;
      else if (cap_d)       pend_d <= 1'b1;
      if (cap_i) begin
        pend_i_type <= i_rd_type;
        pend_i_addr <= i_rd_addr;
      end
      if (cap_d) begin
        pend_d_type <= d_rd_type;
        pend_d_addr <= d_rd_addr;
      end
      // Types 101..111 fall into the line branch since only bit 2 is tested.
      if (grant) begin
        arvalid <= 1'b1;
        owner   <= grant_d;
        if (sel_type[2]) begin
          araddr <= {sel_addr[ADDR_W-1:4], 4'b0000};
          arlen  <= LINE_LEN;
          arsize <= 3'd3;
        end else begin
          araddr <= sel_addr;
          arlen  <= 8'd0;
          arsize <= {1'b0, sel_type[1:0]};
        end
      end
      if ((state == ADDR) & arvalid & arready) begin
        arvalid <= 1'b0;
        rready  <= 1'b1;
      end
      if (beat) begin
        if ((rresp != 2'b00) | (rid != owner)) rd_err <= 1'b1;
        if (rlast) rready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Directed bench for cache_rd_arbiter: a transaction-level model checked every cycle plus literal spot checks.
module tb_cache_rd_arbiter;

  logic        clock, reset;
  logic        i_rd_req, d_rd_req;
  logic [2:0]  i_rd_type, d_rd_type;
  logic [31:0] i_rd_addr, d_rd_addr;
  logic        i_rd_rdy, d_rd_rdy;
  logic        i_ret_valid, i_ret_last, d_ret_valid, d_ret_last;
  logic [63:0] i_ret_data, d_ret_data;
  logic        arvalid, arready, arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready, rlast, rid, rd_err;
  logic [63:0] rdata;
  logic [1:0]  rresp;

  int checks = 0;
  int errors = 0;

  cache_rd_arbiter dut (
    .clock(clock), .reset(reset),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
    .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .rlast(rlast), .rid(rid), .rresp(rresp), .rd_err(rd_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {bit v; bit [2:0] t; bit [31:0] a;} req_t;
  req_t        slot [2];   // index 0 = I-cache, 1 = D-cache
  req_t        inc  [2];
  req_t        r;
  int          phase;      // 0 idle, 1 address offered, 2 data
  int          win;
  bit          own, err, m_on, wi, wd;
  bit [31:0]   e_addr;
  bit [7:0]    e_len;
  bit [2:0]    e_size;
`ifdef CACHE_RD_ARB_RR_EN
  int          last_tie;
`endif

  function automatic bit m_rdy(input int who);
    return !slot[who].v && !(phase != 0 && int'(own) == who);
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      for (int w = 0; w < 2; w++) slot[w] = '{0, 3'd0, 32'd0};
      phase = 0; own = 0; err = 0; e_addr = 0; e_len = 0; e_size = 0; m_on = 1;
`ifdef CACHE_RD_ARB_RR_EN
      last_tie = 0;
`endif
    end else if (m_on) begin
      inc[0] = '{i_rd_req && m_rdy(0), i_rd_type, i_rd_addr};
      inc[1] = '{d_rd_req && m_rdy(1), d_rd_type, d_rd_addr};
      if (phase == 2) begin
        if (rvalid) begin
          if (rresp != 0 || rid != own) err = 1;
          if (rlast) phase = 0;
        end
      end else if (phase == 1) begin
        if (arready) phase = 2;
      end else begin
        wi = slot[0].v || inc[0].v;
        wd = slot[1].v || inc[1].v;
        if (wi || wd) begin
          if (wi && wd) begin
`ifdef CACHE_RD_ARB_RR_EN
            win = 1 - last_tie;
            last_tie = win;
`else
            win = 1;
`endif
          end else begin
            win = wd ? 1 : 0;
          end
          r = slot[win].v ? slot[win] : inc[win];
          slot[win].v = 0;
          inc[win].v = 0;
          if (r.t >= 3'd4) begin
            e_addr = r.a - (r.a % 16);
            e_len  = 8'd1;
            e_size = 3'd3;
          end else begin
            e_addr = r.a;
            e_len  = 8'd0;
            e_size = 3'(r.t);
          end
          own = (win == 1);
          phase = 1;
        end
      end
      for (int w = 0; w < 2; w++) if (inc[w].v) slot[w] = inc[w];
    end
  end

  always @(negedge clock) begin
    if (m_on) begin
      chk("arvalid", arvalid, phase == 1);
      chk("araddr", araddr, e_addr);
      chk("arlen", arlen, e_len);
      chk("arsize", arsize, e_size);
      chk("arid", arid, own);
      chk("arburst", arburst, 2'b01);
      chk("rready", rready, phase == 2);
      chk("rd_err", rd_err, err);
      chk("i_rd_rdy", i_rd_rdy, m_rdy(0));
      chk("d_rd_rdy", d_rd_rdy, m_rdy(1));
      chk("i_ret_valid", i_ret_valid, phase == 2 && rvalid && !own);
      chk("i_ret_last", i_ret_last, phase == 2 && rvalid && !own && rlast);
      chk("i_ret_data", i_ret_data, (phase == 2 && rvalid && !own) ? rdata : 64'd0);
      chk("d_ret_valid", d_ret_valid, phase == 2 && rvalid && own);
      chk("d_ret_last", d_ret_last, phase == 2 && rvalid && own && rlast);
      chk("d_ret_data", d_ret_data, (phase == 2 && rvalid && own) ? rdata : 64'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clock);
    #2;
    i_rd_req = 0; d_rd_req = 0; arready = 0;
    rvalid = 0; rlast = 0; rresp = 2'b00; rid = 0; rdata = 64'd0;
  endtask

  // Call when the next cycle is the one with arvalid high.
  task automatic xfer(input logic id, input int nb, input logic [63:0] base);
    cyc(); arready = 1;
    for (int b = 0; b < nb; b++) begin
      cyc(); rvalid = 1; rid = id; rdata = base + 64'(b); rlast = (b == nb - 1);
    end
  endtask

`ifdef CACHE_RD_ARB_RR_EN
  localparam logic TIE2_D = 1'b0;
`else
  localparam logic TIE2_D = 1'b1;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0; m_on = 0;
    i_rd_req = 0; d_rd_req = 0; i_rd_type = 0; d_rd_type = 0; i_rd_addr = 0; d_rd_addr = 0;
    arready = 0; rvalid = 0; rlast = 0; rresp = 0; rid = 0; rdata = 0;
    repeat (3) cyc();
    reset = 1;
    #4;
    chk("rst_i_rdy", i_rd_rdy, 1); chk("rst_d_rdy", d_rd_rdy, 1);
    chk("rst_arvalid", arvalid, 0); chk("rst_rready", rready, 0);
    chk("rst_rd_err", rd_err, 0); chk("rst_arburst", arburst, 2'b01);

    // I-cache line refill
    cyc(); i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h8000_1238;
    cyc(); arready = 1;
    #4;
    chk("t1_arvalid", arvalid, 1); chk("t1_araddr", araddr, 32'h8000_1230);
    chk("t1_arlen", arlen, 1); chk("t1_arsize", arsize, 3); chk("t1_arid", arid, 0);
    cyc(); rvalid = 1; rid = 0; rdata = 64'h1111_1111_1111_1111;
    #4;
    chk("t1_b0_valid", i_ret_valid, 1); chk("t1_b0_data", i_ret_data, 64'h1111_1111_1111_1111);
    chk("t1_b0_last", i_ret_last, 0); chk("t1_b0_dvalid", d_ret_valid, 0);
    cyc(); rvalid = 1; rid = 0; rlast = 1; rdata = 64'h2222_2222_2222_2222;
    #4;
    chk("t1_b1_last", i_ret_last, 1); chk("t1_b1_data", i_ret_data, 64'h2222_2222_2222_2222);
    cyc(); rvalid = 1; rdata = 64'hdead;   // stray beat while idle
    #4;
    chk("t1_idle_rready", rready, 0); chk("t1_idle_ivalid", i_ret_valid, 0);

    // Simultaneous I and D line requests
    cyc(); i_rd_req = 1; d_rd_req = 1; i_rd_type = 3'b100; d_rd_type = 3'b100;
    i_rd_addr = 32'h0000_1000; d_rd_addr = 32'h0000_2010;
    cyc(); arready = 1;
    #4;
    chk("t2_arid_d", arid, 1); chk("t2_araddr_d", araddr, 32'h0000_2010);
    chk("t2_i_rdy", i_rd_rdy, 0); chk("t2_d_rdy", d_rd_rdy, 0);
    cyc(); rvalid = 1; rid = 1; rdata = 64'hd0;
    #4;
    chk("t2_dvalid", d_ret_valid, 1); chk("t2_ivalid", i_ret_valid, 0);
    cyc(); rvalid = 1; rid = 1; rdata = 64'hd1; rlast = 1;
    cyc();
    cyc(); arready = 1;
    #4;
    chk("t2_arid_i", arid, 0); chk("t2_araddr_i", araddr, 32'h0000_1000);
    cyc(); rvalid = 1; rdata = 64'hc0;
    cyc(); rvalid = 1; rdata = 64'hc1; rlast = 1;

    // Second tie: round-robin flips the winner
    cyc(); i_rd_req = 1; d_rd_req = 1; i_rd_type = 3'b111; d_rd_type = 3'b100;
    i_rd_addr = 32'h0000_3004; d_rd_addr = 32'h0000_4008;
    #4;
    cyc(); arready = 1;
    #4;
    chk("t2b_arid", arid, TIE2_D);
    chk("t2b_araddr", araddr, TIE2_D ? 32'h0000_4000 : 32'h0000_3000);
    for (int b = 0; b < 2; b++) begin
      cyc(); rvalid = 1; rid = TIE2_D; rdata = 64'(b); rlast = (b == 1);
    end
    cyc();
    xfer(~TIE2_D, 2, 64'h50);

    // D-cache word read
    cyc(); d_rd_req = 1; d_rd_type = 3'b010; d_rd_addr = 32'hA000_0004;
    cyc(); arready = 1;
    #4;
    chk("t3_arlen", arlen, 0); chk("t3_arsize", arsize, 2);
    chk("t3_araddr", araddr, 32'hA000_0004); chk("t3_arid", arid, 1);
    cyc(); rvalid = 1; rid = 1; rlast = 1; rdata = 64'h55;
    cyc();
    #4;
    chk("t3_rready", rready, 0); chk("t3_d_rdy", d_rd_rdy, 1);

    // AR stall with I posting during it
    cyc(); d_rd_req = 1; d_rd_type = 3'b011; d_rd_addr = 32'h1000_0008;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (k == 1) begin i_rd_req = 1; i_rd_type = 3'b000; i_rd_addr = 32'h2000_0003; end
      #4;
      chk("t4_arvalid", arvalid, 1); chk("t4_araddr", araddr, 32'h1000_0008);
      chk("t4_arsize", arsize, 3); chk("t4_d_rdy", d_rd_rdy, 0);
      chk("t4_i_rdy", i_rd_rdy, (k <= 1) ? 1 : 0);
    end
    cyc(); arready = 1;
    cyc(); rvalid = 1; rid = 1; rlast = 1; rdata = 64'h77;
    cyc();
    cyc(); arready = 1;
    #4;
    chk("t4_i_araddr", araddr, 32'h2000_0003); chk("t4_i_arsize", arsize, 0);
    chk("t4_i_arlen", arlen, 0); chk("t4_i_arid", arid, 0);
    cyc(); rvalid = 1; rid = 0; rlast = 1; rdata = 64'h88;

    // Error response, then reset mid-DATA
    cyc(); i_rd_req = 1; i_rd_type = 3'b001; i_rd_addr = 32'h3000_0002;
    cyc(); arready = 1;
    cyc(); rvalid = 1; rid = 0; rlast = 1; rresp = 2'b10; rdata = 64'h99;
    #4;
    chk("t5_fwd", i_ret_valid, 1);
    cyc();
    #4;
    chk("t5_err", rd_err, 1); chk("t5_rready", rready, 0);
    repeat (3) cyc();
    #4;
    chk("t5_err_sticky", rd_err, 1);
    cyc(); d_rd_req = 1; d_rd_type = 3'b100; d_rd_addr = 32'h5000_0020;
    cyc(); arready = 1;
    cyc(); rvalid = 1; rid = 1; rdata = 64'haa;
    cyc(); reset = 0;
    #4;
    chk("t5_pre_rst_rready", rready, 1);
    cyc(); reset = 1;
    #4;
    chk("t5_rst_rready", rready, 0); chk("t5_rst_arvalid", arvalid, 0);
    chk("t5_rst_i_rdy", i_rd_rdy, 1); chk("t5_rst_d_rdy", d_rd_rdy, 1);
    chk("t5_rst_err", rd_err, 0);

    // rid mismatch also flags an error
    cyc(); i_rd_req = 1; i_rd_type = 3'b010; i_rd_addr = 32'h6000_0000;
    cyc(); arready = 1;
    cyc(); rvalid = 1; rid = 1; rlast = 1; rdata = 64'hbb;
    #4;
    chk("t6_fwd_i", i_ret_valid, 1);
    cyc();
    #4;
    chk("t6_err", rd_err, 1);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
